vsa_mem_arbiter: RTL

- Shares one single-port, 1-cycle-read-latency memory among three requesters: the VSA core data port (LW/SW), the VSA core instruction-fetch port, and a program loader/debug port.
- Sits between the core and the unified memory.
- Fixed priority (data > ifetch > loader), with an aging counter that bounds loader starvation and a loader lock that fences off the core.

---
 rtl/vsa_mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vsa_mem_arbiter.sv
// vsa_mem_arbiter: shares one single-port memory (1-cycle read latency)
// between the VSA core data port, the core instruction-fetch port and a
// program loader/debug port. Fixed priority data > ifetch > loader, with
// an aging counter that forces a loader win after MAX_WAIT lost
// arbitrations, and a loader lock that fences off the core.
//
// Ports:
//   clock, reset_n         master clock, synchronous active-low reset
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid   core data port
//   i_req/i_addr              -> i_gnt, i_rvalid   core fetch port (read only)
//   l_req/l_we/l_addr/l_wdata/l_lock -> l_gnt, l_rvalid   loader port
//   rdata                  shared read data, valid with any rvalid
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata   memory interface
//   busy                   high while an access is in flight
// Every access is IDLE -> ACCESS -> DONE; all outputs are registered.
module vsa_mem_arbiter #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {P_NONE, P_DATA, P_FETCH, P_LOAD} port_t;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  state_t              r_state, w_state_nxt;
  port_t               r_win, w_win_nxt, w_arb;
  logic                r_we, w_we_nxt;
  logic [3:0]          r_wait_cnt, w_wait_cnt_nxt;
  logic                r_d_gnt, r_i_gnt, r_l_gnt, w_d_gnt, w_i_gnt, w_l_gnt;
  logic                r_d_rv, r_i_rv, r_l_rv, w_d_rv, w_i_rv, w_l_rv;
  logic                r_mem_en, r_mem_we, w_mem_en, w_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;
  logic [DATA_W-1:0]   r_rdata, w_rdata;
  logic                r_busy, w_busy;
  logic                w_d_elig, w_i_elig;

  // Arbitration: the aging limit overrides the fixed priority order.
  always_comb begin
    w_d_elig = d_req & ~l_lock;
    w_i_elig = i_req & ~l_lock;
    if (l_req && (r_wait_cnt == LP_MAX_WAIT)) w_arb = P_LOAD;
    else if (w_d_elig)                        w_arb = P_DATA;
    else if (w_i_elig)                        w_arb = P_FETCH;
    else if (l_req)                           w_arb = P_LOAD;
    else                                      w_arb = P_NONE;
  end

  // Next-state and next-output logic. mem_addr/mem_wdata double as the
  // latched request fields, so they hold outside of arbitration.
  always_comb begin
    w_state_nxt    = r_state;
    w_win_nxt      = r_win;
    w_we_nxt       = r_we;
    w_wait_cnt_nxt = r_wait_cnt;
    w_d_gnt        = 1'b0;
    w_i_gnt        = 1'b0;
    w_l_gnt        = 1'b0;
    w_d_rv         = 1'b0;
    w_i_rv         = 1'b0;
    w_l_rv         = 1'b0;
    w_mem_en       = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = r_mem_addr;
    w_mem_wdata    = r_mem_wdata;
    w_rdata        = r_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (!l_req)                   w_wait_cnt_nxt = '0;
        else if (w_arb == P_LOAD)     w_wait_cnt_nxt = '0;
        else if (r_wait_cnt < LP_MAX_WAIT) w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        if (w_arb != P_NONE) begin
          w_state_nxt = S_ACCESS;
          w_win_nxt   = w_arb;
          w_mem_en    = 1'b1;
          unique case (w_arb)
            P_DATA: begin
              w_we_nxt    = d_we;
              w_mem_addr  = d_addr;
              w_mem_wdata = d_wdata;
              w_d_gnt     = 1'b1;
            end
            P_FETCH: begin
              w_we_nxt    = 1'b0;
              w_mem_addr  = i_addr;
              w_mem_wdata = '0;
              w_i_gnt     = 1'b1;
            end
            default: begin
              w_we_nxt    = l_we;
              w_mem_addr  = l_addr;
              w_mem_wdata = l_wdata;
              w_l_gnt     = 1'b1;
            end
          endcase
          w_mem_we = w_we_nxt;
        end
      end
      S_ACCESS: w_state_nxt = S_DONE;
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (!r_we) begin
          w_rdata = mem_rdata;
          w_d_rv  = (r_win == P_DATA);
          w_i_rv  = (r_win == P_FETCH);
          w_l_rv  = (r_win == P_LOAD);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_win       <= P_NONE;
      r_we        <= 1'b0;
      r_wait_cnt  <= '0;
      r_d_gnt     <= 1'b0;
      r_i_gnt     <= 1'b0;
      r_l_gnt     <= 1'b0;
      r_d_rv      <= 1'b0;
      r_i_rv      <= 1'b0;
      r_l_rv      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_win       <= w_win_nxt;
      r_we        <= w_we_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_d_gnt     <= w_d_gnt;
      r_i_gnt     <= w_i_gnt;
      r_l_gnt     <= w_l_gnt;
      r_d_rv      <= w_d_rv;
      r_i_rv      <= w_i_rv;
      r_l_rv      <= w_l_rv;
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_rdata     <= w_rdata;
      r_busy      <= w_busy;
    end
  end

  assign d_gnt     = r_d_gnt;
  assign i_gnt     = r_i_gnt;
  assign l_gnt     = r_l_gnt;
  assign d_rvalid  = r_d_rv;
  assign i_rvalid  = r_i_rv;
  assign l_rvalid  = r_l_rv;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;
  assign busy      = r_busy;

endmodule
